// File: rtl/mash_pkg.sv
// Shared constants for the MASH 1-1-1 modulator.
//   OUT_W      width of the signed modulator output
//   LFSR_W     width of the dither LFSR
//   LFSR_TAPS  feedback mask for a Fibonacci LFSR with taps 16,14,13,11
//   ncn_min/ncn_max  NCN output range for a given modulator order
package mash_pkg;

  localparam int unsigned OUT_W  = 4;
  localparam int unsigned LFSR_W = 16;
  // Tap positions 16,14,13,11 map to bit indices 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic int ncn_min(input int unsigned order);
    case (order)
      1:       return 0;
      2:       return -1;
      default: return -3;
    endcase
  endfunction

  function automatic int ncn_max(input int unsigned order);
    case (order)
      1:       return 1;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// One MASH accumulator stage: e_out accumulates in_val modulo 2^WIDTH,
// c_out is the registered overflow of that addition.
//   clk, rst_n  clock, asynchronous active-low reset
//   en          clock enable; 0 holds e_out and c_out
//   in_val      addend, one bit wider than the accumulator so stage 1 can
//               carry frac + dither without losing the top bit
//   e_out       registered accumulator (quantisation error)
//   c_out       registered carry out
module mash_acc_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH:0]   in_val,
  output logic [WIDTH-1:0] e_out,
  output logic             c_out
);

  // Max sum is (2^W - 1) + 2^W, so bit W is the single carry.
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, e_out} + in_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_out <= '0;
      c_out <= 1'b0;
    end else if (en) begin
      e_out <= sum[WIDTH-1:0];
      c_out <= sum[WIDTH];
    end
  end

endmodule

// File: rtl/mash_modulator.sv
// MASH 1-1-1 delta-sigma modulator, order 1..3, with noise-cancellation
// network, clock enable, guarded fraction load and optional LFSR dither.
//   clk, rst_n  clock, asynchronous active-low reset
//   en          clock enable; 0 freezes all modulator state
//   frac_in     fractional input word
//   frac_load   capture frac_in into frac_q (independent of en)
//   dither_en   add LFSR bit 0 to the stage-1 LSB
//   out_val     signed NCN output, long-run mean = frac/2^WIDTH
//   out_valid   out_val meaningful this cycle
//   c1_dbg      registered stage-1 carry
module mash_modulator
  import mash_pkg::*;
#(
  parameter int unsigned       WIDTH = 16,
  parameter int unsigned       ORDER = 3,
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [WIDTH-1:0]        frac_in,
  input  logic                    frac_load,
  input  logic                    dither_en,
  output logic signed [OUT_W-1:0] out_val,
  output logic                    out_valid,
  output logic                    c1_dbg
);

  if (ORDER < 1 || ORDER > 3) begin : g_bad_order
    $error("mash_modulator: ORDER must be 1..3");
  end
  if (WIDTH < 8 || WIDTH > 32) begin : g_bad_width
    $error("mash_modulator: WIDTH must be 8..32");
  end

  localparam logic [2:0] WARM_SAT = 3'(ORDER + 1);

  logic [WIDTH-1:0]  frac_q;
  logic [LFSR_W-1:0] lfsr;
  logic              dither_bit;
  logic [WIDTH:0]    stage_in [ORDER];
  logic [WIDTH-1:0]  acc      [ORDER];
  logic [ORDER-1:0]  carry;
  logic [OUT_W-1:0]  ncn_y;
  logic [2:0]        warm_cnt;
  logic [2:0]        warm_nxt;
  logic              unused_last_acc;

  // The last stage's residue feeds nothing further.
  assign unused_last_acc = ^acc[ORDER-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frac_q <= '0;
    end else if (frac_load) begin
      frac_q <= frac_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign dither_bit = dither_en & lfsr[0];

  always_comb begin
    stage_in[0] = {1'b0, frac_q} + {{WIDTH{1'b0}}, dither_bit};
    for (int unsigned k = 1; k < ORDER; k++) begin
      stage_in[k] = {1'b0, acc[k-1]};
    end
  end

  for (genvar k = 0; k < int'(ORDER); k++) begin : g_stage
    mash_acc_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .in_val (stage_in[k]),
      .e_out  (acc[k]),
      .c_out  (carry[k])
    );
  end

  assign c1_dbg = carry[0];

  // NCN: carries are delayed so that each stage's pipelined carry lines up
  // with the stage-1 carry. 4-bit modulo arithmetic yields the correct
  // two's-complement result because the true value always fits.
  if (ORDER == 1) begin : g_ncn1
    assign ncn_y = {3'b000, carry[0]};
  end else if (ORDER == 2) begin : g_ncn2
    logic c1d, c2d;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c1d <= 1'b0;
        c2d <= 1'b0;
      end else if (en) begin
        c1d <= carry[0];
        c2d <= carry[1];
      end
    end
    assign ncn_y = {3'b000, c1d} + {3'b000, carry[1]} - {3'b000, c2d};
  end else begin : g_ncn3
    logic c1d, c1dd, c2d, c2dd, c3d, c3dd;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c1d  <= 1'b0;
        c1dd <= 1'b0;
        c2d  <= 1'b0;
        c2dd <= 1'b0;
        c3d  <= 1'b0;
        c3dd <= 1'b0;
      end else if (en) begin
        c1d  <= carry[0];
        c1dd <= c1d;
        c2d  <= carry[1];
        c2dd <= c2d;
        c3d  <= carry[2];
        c3dd <= c3d;
      end
    end
    assign ncn_y = {3'b000, c1dd} + {3'b000, c2d} - {3'b000, c2dd}
                 + {3'b000, carry[2]} - {2'b00, c3d, 1'b0} + {3'b000, c3dd};
  end

  assign warm_nxt = (warm_cnt == WARM_SAT) ? warm_cnt : warm_cnt + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt  <= '0;
      out_val   <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      warm_cnt  <= warm_nxt;
      out_val   <= $signed(ncn_y);
      out_valid <= (warm_nxt == WARM_SAT);
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mash_modulator.sv
// Self-checking bench: ORDER=1 and ORDER=3 instances share one stimulus and
// are compared every cycle against a reference built from the carry
// sequences indexed by enabled-edge number.
module tb_mash_modulator;
  import mash_pkg::*;

  localparam int unsigned W = 16;
  localparam longint      M = 65536;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [W-1:0]      frac_in;
  logic              frac_load;
  logic              dither_en;
  logic signed [3:0] out1, out3;
  logic              v1, v3, c1a, c1b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mash_modulator #(.WIDTH(W), .ORDER(1), .SEED(16'hACE1)) u_o1 (
    .clk(clk), .rst_n(rst_n), .en(en), .frac_in(frac_in),
    .frac_load(frac_load), .dither_en(dither_en),
    .out_val(out1), .out_valid(v1), .c1_dbg(c1a)
  );

  mash_modulator #(.WIDTH(W), .ORDER(3), .SEED(16'hACE1)) u_o3 (
    .clk(clk), .rst_n(rst_n), .en(en), .frac_in(frac_in),
    .frac_load(frac_load), .dither_en(dither_en),
    .out_val(out3), .out_valid(v3), .c1_dbg(c1b)
  );

  // ---------------- reference model ----------------
  longint      a1, a2, a3, fq;
  logic [15:0] ml;
  int          n;
  bit          last_en;
  int          c1q[$], c2q[$], c3q[$];

  // window statistics for the ORDER=3 instance
  longint sum3;
  int     nvalid3, range_bad, min3, max3;

  function automatic int cx(input int k, input int m);
    if (m < 1) return 0;
    case (k)
      1:       return c1q[m-1];
      2:       return c2q[m-1];
      default: return c3q[m-1];
    endcase
  endfunction

  task automatic model_reset();
    a1 = 0; a2 = 0; a3 = 0; fq = 0;
    ml = 16'hACE1; n = 0; last_en = 1'b0;
    c1q.delete(); c2q.delete(); c3q.delete();
  endtask

  task automatic model_edge();
    longint s1, s2, s3;
    longint d;
    last_en = en;
    if (en) begin
      d  = (dither_en && ml[0]) ? 1 : 0;
      s1 = a1 + fq + d;
      s2 = a2 + a1;
      s3 = a3 + a2;
      a1 = s1 % M; a2 = s2 % M; a3 = s3 % M;
      c1q.push_back(int'(s1 >= M));
      c2q.push_back(int'(s2 >= M));
      c3q.push_back(int'(s3 >= M));
      ml = {ml[14:0], ml[15] ^ ml[13] ^ ml[12] ^ ml[10]};
      n++;
    end
    if (frac_load) fq = longint'(frac_in);
  endtask

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clr_stats();
    sum3 = 0; nvalid3 = 0; range_bad = 0; min3 = 99; max3 = -99;
  endtask

  task automatic compare_all();
    int e1, e3;
    e1 = cx(1, n-1);
    e3 = cx(1, n-3) + cx(2, n-2) - cx(2, n-3)
       + cx(3, n-1) - 2*cx(3, n-2) + cx(3, n-3);
    check_val("o1_out_val",   longint'(out1), e1);
    check_val("o3_out_val",   longint'(out3), e3);
    check_val("o1_out_valid", longint'(v1), (last_en && n >= 2) ? 1 : 0);
    check_val("o3_out_valid", longint'(v3), (last_en && n >= 4) ? 1 : 0);
    check_val("o1_c1_dbg",    longint'(c1a), cx(1, n));
    check_val("o3_c1_dbg",    longint'(c1b), cx(1, n));
    if (v3) begin
      sum3 += longint'(out3);
      nvalid3++;
      if (int'(out3) < ncn_min(3) || int'(out3) > ncn_max(3)) range_bad++;
      if (int'(out3) < min3) min3 = int'(out3);
      if (int'(out3) > max3) max3 = int'(out3);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_o1_out_val"},   longint'(out1), 0);
    check_val({tag, "_o3_out_val"},   longint'(out3), 0);
    check_val({tag, "_o1_out_valid"}, longint'(v1), 0);
    check_val({tag, "_o3_out_valid"}, longint'(v3), 0);
    check_val({tag, "_o1_c1_dbg"},    longint'(c1a), 0);
    check_val({tag, "_o3_c1_dbg"},    longint'(c1b), 0);
  endtask

  // Hold reset with hostile inputs for a few edges; outputs must stay 0.
  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; frac_in = 16'hFFFF; frac_load = 1'b1; dither_en = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero("rst");
    end
    model_reset();
    rst_n = 1'b1; frac_load = 1'b0; en = 1'b0;
  endtask

  task automatic load_frac(input logic [W-1:0] f);
    frac_in = f; frac_load = 1'b1; en = 1'b1;
    tick();
    frac_load = 1'b0;
  endtask

  // Run until 'want' ORDER=3 valid outputs are seen, bounded by a cycle budget.
  task automatic run_valid(input int want, input string tag);
    int cyc;
    cyc = 0;
    clr_stats();
    while (nvalid3 < want && cyc < want + 100) begin
      tick();
      cyc++;
    end
    check_val({tag, "_valid_count"}, nvalid3, want);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; frac_in = '0; frac_load = 1'b0; dither_en = 1'b0;
    model_reset();
    clr_stats();

    // Reset with all-ones fraction and en=1
    do_reset();

    // ORDER=1 half-rate: alternating 0,1
    load_frac(16'h8000);
    repeat (40) tick();

    // Zero fraction gives zero output
    do_reset();
    load_frac(16'h0000);
    clr_stats();
    repeat (100) begin
      tick();
      if (v3) check_val("zero_frac_o3", longint'(out3), 0);
    end

    // Quarter fraction: long-run sum and NCN range
    do_reset();
    load_frac(16'h4000);
    run_valid(16384, "quarter");
    check_val("quarter_sum",
              (sum3 >= 4093 && sum3 <= 4099) ? 4096 : sum3, 4096);
    check_val("quarter_range", range_bad, 0);

    // Clock-enable freeze mid-run
    do_reset();
    load_frac(16'h2345);
    repeat (30) tick();
    en = 1'b0;
    repeat (10) begin
      tick();
      check_val("freeze_o3_valid", longint'(v3), 0);
    end
    en = 1'b1;
    repeat (40) tick();

    // Randomized enable / load / dither, including load coinciding with en
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      frac_load = ($urandom_range(0, 15) == 0);
      frac_in   = W'($urandom);
      if ((i % 256) == 0) dither_en = $urandom_range(0, 1) == 1;
      tick();
    end
    frac_load = 1'b0;

    // Dithered tiny fraction: output must move; then async reset mid-run
    do_reset();
    dither_en = 1'b1;
    load_frac(16'h0001);
    clr_stats();
    repeat (3000) tick();
    check_val("dither_varies", (max3 > min3) ? 1 : 0, 1);
    check_val("dither_range", range_bad, 0);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    do_reset();

    // Dithered quarter fraction: mean stays at frac plus half an LSB
    dither_en = 1'b1;
    load_frac(16'h4000);
    run_valid(16384, "dq");
    check_val("dither_quarter_sum",
              (sum3 >= 4091 && sum3 <= 4101) ? 4096 : sum3, 4096);
    check_val("dither_quarter_range", range_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
